branch_sequencer: RTL

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/branch_cond_eval.sv | 24 ++
 rtl/branch_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch opcodes, branch condition codes, sequencer states
// and the branch-target helper.
package cpu_pkg;

  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_BLE = 6'h06;
  localparam logic [5:0] OP_BGT = 6'h07;

  typedef enum logic [1:0] {
    BOP_ET  = 2'b00,
    BOP_NET = 2'b01,
    BOP_GT  = 2'b10,
    BOP_LT  = 2'b11
  } branch_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMP   = 2'd1,
    ST_EVAL  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLE) || (op == OP_BGT);
  endfunction

  function automatic branch_op_e decode_op(input logic [5:0] op);
    branch_op_e bop;
    case (op)
      OP_BNE:  bop = BOP_NET;
      OP_BLE:  bop = BOP_LT;
      OP_BGT:  bop = BOP_GT;
      default: bop = BOP_ET;
    endcase
    return bop;
  endfunction

  // Word offset becomes a byte offset; the add wraps modulo 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [15:0] off);
    return pc4 + {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition: maps the condition code and captured ALU flags
// to a taken decision. Flags are used as given, with no consistency check.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  branch_op_e branch_op,
  input  logic       gt,
  input  logic       lt,
  input  logic       et,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (branch_op)
      BOP_ET:  taken = et;
      BOP_NET: taken = !et;
      BOP_GT:  taken = gt;
      BOP_LT:  taken = lt | et;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Branch sequencer: IDLE -> CMP -> EVAL -> WRITE, requesting an ALU compare and
// producing the next PC. Optional compare timeout via the BRANCH_TIMEOUT_EN macro.
module branch_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [15:0] offset,
  input  logic [31:0] pc_plus4,
  input  logic        cmp_valid,
  input  logic        gt,
  input  logic        lt,
  input  logic        et,
  output logic        alu_cmp_req,
  output logic [1:0]  branch_op,
  output logic        pc_write,
  output logic [31:0] pc_next,
  output logic        busy,
  output logic        illegal
`ifdef BRANCH_TIMEOUT_EN
  ,
  output logic        timeout
`endif
);

  state_e     state_q, state_d;
  branch_op_e bop_q, bop_d;
  logic [15:0] offset_q, offset_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] pc_next_q, pc_next_d;
  logic        gt_q, gt_d, lt_q, lt_d, et_q, et_d;
  logic        illegal_q, illegal_d;
  logic        taken;
`ifdef BRANCH_TIMEOUT_EN
  logic [3:0]  tmo_cnt_q, tmo_cnt_d;
  logic        timeout_q, timeout_d;
`endif

  branch_cond_eval u_cond (
    .branch_op (bop_q),
    .gt        (gt_q),
    .lt        (lt_q),
    .et        (et_q),
    .taken     (taken)
  );

  always_comb begin
    state_d   = state_q;
    bop_d     = bop_q;
    offset_d  = offset_q;
    pc4_d     = pc4_q;
    pc_next_d = pc_next_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    et_d      = et_q;
    illegal_d = 1'b0;
`ifdef BRANCH_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef BRANCH_TIMEOUT_EN
        tmo_cnt_d = 4'd0;
`endif
        if (start) begin
          if (is_branch(opcode)) begin
            bop_d    = decode_op(opcode);
            offset_d = offset;
            pc4_d    = pc_plus4;
            state_d  = ST_CMP;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_CMP: begin
        if (cmp_valid) begin
          gt_d    = gt;
          lt_d    = lt;
          et_d    = et;
          state_d = ST_EVAL;
        end
`ifdef BRANCH_TIMEOUT_EN
        // Sixteenth CMP cycle without a compare result: fall through not-taken.
        else if (tmo_cnt_q == 4'hF) begin
          pc_next_d = pc4_q;
          timeout_d = 1'b1;
          state_d   = ST_WRITE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 4'd1;
        end
`endif
      end
      ST_EVAL: begin
        pc_next_d = taken ? branch_target(pc4_q, offset_q) : pc4_q;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bop_q     <= BOP_ET;
      offset_q  <= '0;
      pc4_q     <= '0;
      pc_next_q <= '0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      et_q      <= 1'b0;
      illegal_q <= 1'b0;
`ifdef BRANCH_TIMEOUT_EN
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bop_q     <= bop_d;
      offset_q  <= offset_d;
      pc4_q     <= pc4_d;
      pc_next_q <= pc_next_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
      et_q      <= et_d;
      illegal_q <= illegal_d;
`ifdef BRANCH_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign alu_cmp_req = (state_q == ST_CMP);
  assign pc_write    = (state_q == ST_WRITE);
  assign busy        = (state_q != ST_IDLE);
  assign branch_op   = bop_q;
  assign pc_next     = pc_next_q;
  assign illegal     = illegal_q;
`ifdef BRANCH_TIMEOUT_EN
  assign timeout     = timeout_q;
`endif

endmodule
